counter_timer_dev: RTL and testbench

Three-channel 32-bit down-counter/timer peripheral driven by the CPU peripheral bus. Consumes the 2-bit `counter_set` selector produced by the GPIO/LED device to choose which channel register a bus write lands in, and which register `counter_out` returns. Provides per-channel terminal outputs and a combined sticky interrupt request.

---
 rtl/counter_timer_dev_if.sv | 22 ++
 rtl/counter_timer_dev.sv | 137 +++++++++++++
 tb/tb_counter_timer_dev.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/counter_timer_dev_if.sv
// Peripheral bus bundle for the counter/timer: write strobe, register select,
// write data and the selected register's read data.
interface counter_timer_dev_if;
    logic        counter_we;
    logic [1:0]  counter_set;
    logic [31:0] Peripheral_in;
    logic [31:0] counter_out;

    modport master (
        output counter_we,
        output counter_set,
        output Peripheral_in,
        input  counter_out
    );

    modport slave (
        input  counter_we,
        input  counter_set,
        input  Peripheral_in,
        output counter_out
    );
endinterface

// File: rtl/counter_timer_dev.sv
// Three-channel down-counter/timer with one-shot, auto-reload and square-wave
// modes, sticky terminal flags and a combined interrupt request.
module counter_timer_dev #(
    parameter int CH_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    counter_timer_dev_if.slave bus,
    output logic               counter0_out,
    output logic               counter1_out,
    output logic               counter2_out,
    output logic               irq
);

    localparam logic [1:0]  MODE_AUTO   = 2'b01;
    localparam logic [1:0]  MODE_SQUARE = 2'b10;
    localparam logic [11:0] CTRL_MASK   = 12'h777;

    logic [CH_W-1:0] reload_q [3];
    logic [CH_W-1:0] reload_d [3];
    logic [CH_W-1:0] count_q  [3];
    logic [CH_W-1:0] count_d  [3];
    logic [11:0]     ctrl_q, ctrl_d;
    logic [2:0]      flag_q, flag_d;
    logic [2:0]      out_q, out_d;

    logic [2:0]      en;
    logic [1:0]      mode [3];
    logic [2:0]      term;
    logic [2:0]      chan_out;
    logic            ctrl_wr;

    // Terminal events are judged on the registered control, so a control write
    // landing in the terminal cycle cannot suppress that cycle's event.
    always_comb begin
        for (int n = 0; n < 3; n++) begin
            en[n]   = ctrl_q[4*n];
            mode[n] = ctrl_q[4*n+1 +: 2];
            term[n] = en[n] && (count_q[n] == '0) && (reload_q[n] != '0);
        end
    end

    always_comb begin
        ctrl_d  = ctrl_q;
        flag_d  = flag_q;
        out_d   = out_q;
        ctrl_wr = bus.counter_we && (bus.counter_set == 2'd3);
        for (int n = 0; n < 3; n++) begin
            reload_d[n] = reload_q[n];
            count_d[n]  = count_q[n];
        end

        if (ctrl_wr) begin
            ctrl_d = bus.Peripheral_in[11:0] & CTRL_MASK;
            if (bus.Peripheral_in[31]) begin
                flag_d = '0;
            end
        end

        for (int n = 0; n < 3; n++) begin
            if (en[n] && (count_q[n] != '0)) begin
                count_d[n] = count_q[n] - CH_W'(1);
            end

            if (term[n]) begin
                flag_d[n] = 1'b1;
                case (mode[n])
                    MODE_AUTO: begin
                        count_d[n] = reload_q[n];
                    end
                    MODE_SQUARE: begin
                        count_d[n] = reload_q[n];
                        out_d[n]   = ~out_q[n];
                    end
                    default: begin
                        out_d[n] = 1'b1;
                    end
                endcase
            end

            // A reload write overrides anything the channel did this cycle.
            if (bus.counter_we && (bus.counter_set == 2'(n))) begin
                reload_d[n] = bus.Peripheral_in;
                count_d[n]  = bus.Peripheral_in;
                flag_d[n]   = 1'b0;
                out_d[n]    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= '0;
            flag_q <= '0;
            out_q  <= '0;
            for (int n = 0; n < 3; n++) begin
                reload_q[n] <= '0;
                count_q[n]  <= '0;
            end
        end else begin
            ctrl_q <= ctrl_d;
            flag_q <= flag_d;
            out_q  <= out_d;
            for (int n = 0; n < 3; n++) begin
                reload_q[n] <= reload_d[n];
                count_q[n]  <= count_d[n];
            end
        end
    end

    // Auto-reload pulses only during the zero cycle; one-shot rises in that
    // cycle and is then held by out_q; square wave is purely registered.
    always_comb begin
        for (int n = 0; n < 3; n++) begin
            case (mode[n])
                MODE_AUTO:   chan_out[n] = term[n];
                MODE_SQUARE: chan_out[n] = out_q[n];
                default:     chan_out[n] = out_q[n] | term[n];
            endcase
        end
    end

    assign counter0_out = chan_out[0];
    assign counter1_out = chan_out[1];
    assign counter2_out = chan_out[2];
    assign irq          = |flag_q;

    always_comb begin
        case (bus.counter_set)
            2'd0:    bus.counter_out = count_q[0];
            2'd1:    bus.counter_out = count_q[1];
            2'd2:    bus.counter_out = count_q[2];
            default: bus.counter_out = {flag_q, 17'b0, ctrl_q};
        endcase
    end

endmodule

// File: tb/tb_counter_timer_dev.sv
// Bench for counter_timer_dev: directed scenarios plus randomized single-channel
// runs checked against closed-form expectations of count, output and flag.
module tb_counter_timer_dev;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic c0, c1, c2, irq;
    int   passed = 0;
    int   total  = 0;

    counter_timer_dev_if bus ();

    counter_timer_dev #(.CH_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .counter0_out (c0),
        .counter1_out (c1),
        .counter2_out (c2),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    wire [2:0] outs = {c2, c1, c0};

    // Expected values as functions of k = clock edges since the channel became
    // enabled with reload r already loaded.
    function automatic logic [31:0] m_count(input int md, input int r, input int k);
        if (md == 1 || md == 2) return 32'(r - (k % (r + 1)));
        return (k >= r) ? 32'd0 : 32'(r - k);
    endfunction

    function automatic logic m_out(input int md, input int r, input int k);
        if (md == 1) return (k % (r + 1)) == r;
        if (md == 2) return ((k / (r + 1)) % 2) == 1;
        return k >= r;
    endfunction

    task automatic wr(input logic [1:0] sel, input logic [31:0] data);
        bus.counter_we    = 1'b1;
        bus.counter_set   = sel;
        bus.Peripheral_in = data;
        @(negedge clk);
        bus.counter_we    = 1'b0;
    endtask

    task automatic rd(input logic [1:0] sel, output logic [31:0] v);
        bus.counter_set = sel;
        #1;
        v = bus.counter_out;
    endtask

    task automatic do_reset;
        bus.counter_we = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        rd(2'd0, v);
        total++; if (v !== 32'd0) $display("FAIL rst_count0: got %0h want 0", v); else passed++;
        rd(2'd3, v);
        total++; if (v !== 32'd0) $display("FAIL rst_ctrl: got %0h want 0", v); else passed++;
        total++; if ({outs, irq} !== 4'b0) $display("FAIL rst_outs: got %b want 0000", {outs, irq}); else passed++;
        rst = 1'b0;
        wr(2'd0, 32'd5);
        wr(2'd3, 32'h1);
        @(negedge clk);
        @(negedge clk);
        rd(2'd0, v);
        total++; if (v !== 32'd3) $display("FAIL rst_precount: got %0h want 3", v); else passed++;
        #2 rst = 1'b1;
        rd(2'd0, v);
        total++; if (v !== 32'd0) $display("FAIL rst_async_count: got %0h want 0", v); else passed++;
        total++; if ({outs, irq} !== 4'b0) $display("FAIL rst_async_outs: got %b want 0000", {outs, irq}); else passed++;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rd(2'd0, v);
        total++; if (v !== 32'd0) $display("FAIL rst_after_count: got %0h want 0", v); else passed++;
        rd(2'd3, v);
        total++; if (v !== 32'd0) $display("FAIL rst_after_ctrl: got %0h want 0", v); else passed++;
    endtask

    task automatic test_oneshot;
        logic [31:0] v;
        logic [31:0] exp_cnt [5] = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd0};
        do_reset;
        wr(2'd0, 32'd3);
        wr(2'd3, 32'h001);
        for (int k = 0; k < 5; k++) begin
            rd(2'd0, v);
            total++; if (v !== exp_cnt[k]) $display("FAIL os_count k=%0d: got %0h want %0h", k, v, exp_cnt[k]); else passed++;
            total++; if (c0 !== (k >= 3)) $display("FAIL os_out k=%0d: got %b want %b", k, c0, (k >= 3)); else passed++;
            @(negedge clk);
        end
        total++; if (irq !== 1'b1) $display("FAIL os_irq: got %b want 1", irq); else passed++;
        rd(2'd3, v);
        total++; if (v !== 32'h2000_0001) $display("FAIL os_ctrl_read: got %0h want 20000001", v); else passed++;
        total++; if (c0 !== 1'b1) $display("FAIL os_out_held: got %b want 1", c0); else passed++;
    endtask

    task automatic test_autoreload;
        logic [31:0] v;
        do_reset;
        wr(2'd1, 32'd2);
        wr(2'd3, 32'h030);
        for (int k = 0; k < 9; k++) begin
            total++; if (c1 !== ((k % 3) == 2)) $display("FAIL ar_out k=%0d: got %b want %b", k, c1, ((k % 3) == 2)); else passed++;
            rd(2'd1, v);
            total++; if (v !== 32'(2 - (k % 3))) $display("FAIL ar_count k=%0d: got %0h want %0h", k, v, 2 - (k % 3)); else passed++;
            @(negedge clk);
        end
        total++; if (irq !== 1'b1) $display("FAIL ar_irq_set: got %b want 1", irq); else passed++;
        wr(2'd3, 32'h8000_0030);
        total++; if (irq !== 1'b0) $display("FAIL ar_irq_clear: got %b want 0", irq); else passed++;
        rd(2'd1, v);
        total++; if (v !== 32'd1) $display("FAIL ar_count_after_clr: got %0h want 1", v); else passed++;
        @(negedge clk);
        total++; if ({c1, irq} !== 2'b10) $display("FAIL ar_pulse_noirq: got %b want 10", {c1, irq}); else passed++;
        @(negedge clk);
        total++; if ({c1, irq} !== 2'b01) $display("FAIL ar_irq_reassert: got %b want 01", {c1, irq}); else passed++;
        @(negedge clk);
        @(negedge clk);
        total++; if (c1 !== 1'b1) $display("FAIL ar_pulse2: got %b want 1", c1); else passed++;
        wr(2'd3, 32'h8000_0030);
        total++; if (irq !== 1'b1) $display("FAIL ar_clear_vs_event: got %b want 1", irq); else passed++;
    endtask

    task automatic test_square;
        logic [31:0] v;
        do_reset;
        wr(2'd2, 32'd1);
        wr(2'd3, 32'h500);
        for (int k = 0; k < 9; k++) begin
            total++; if (c2 !== (((k / 2) % 2) == 1)) $display("FAIL sq_out k=%0d: got %b want %b", k, c2, (((k / 2) % 2) == 1)); else passed++;
            @(negedge clk);
        end
        wr(2'd3, 32'h000);
        for (int j = 0; j < 4; j++) begin
            rd(2'd2, v);
            total++; if (v !== 32'd1) $display("FAIL sq_frozen_count j=%0d: got %0h want 1", j, v); else passed++;
            total++; if (c2 !== 1'b1) $display("FAIL sq_frozen_out j=%0d: got %b want 1", j, c2); else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_collision;
        logic [31:0] v;
        do_reset;
        wr(2'd0, 32'd4);
        wr(2'd3, 32'h003);
        repeat (4) @(negedge clk);
        total++; if (c0 !== 1'b1) $display("FAIL col_pulse: got %b want 1", c0); else passed++;
        wr(2'd0, 32'd9);
        rd(2'd0, v);
        total++; if (v !== 32'd9) $display("FAIL col_count: got %0h want 9", v); else passed++;
        total++; if (irq !== 1'b0) $display("FAIL col_irq: got %b want 0", irq); else passed++;
        rd(2'd3, v);
        total++; if (v !== 32'h0000_0003) $display("FAIL col_ctrl_read: got %0h want 3", v); else passed++;
        for (int j = 0; j < 10; j++) begin
            total++; if (c0 !== (j == 9)) $display("FAIL col_next_pulse j=%0d: got %b want %b", j, c0, (j == 9)); else passed++;
            @(negedge clk);
        end
        total++; if (irq !== 1'b1) $display("FAIL col_irq_after: got %b want 1", irq); else passed++;
    endtask

    task automatic test_idle;
        logic [31:0] v;
        do_reset;
        wr(2'd0, 32'd0);
        wr(2'd3, 32'h531);
        for (int j = 0; j < 8; j++) begin
            total++; if ({outs, irq} !== 4'b0) $display("FAIL idle_outs j=%0d: got %b want 0000", j, {outs, irq}); else passed++;
            @(negedge clk);
        end
        rd(2'd3, v);
        total++; if (v !== 32'h0000_0531) $display("FAIL idle_ctrl_read: got %0h want 531", v); else passed++;
    endtask

    task automatic test_random;
        logic [31:0] v, ctrl, exp_v;
        logic [2:0]  exp_outs;
        int ch, md, r, n;
        for (int t = 0; t < 20; t++) begin
            ch = int'($urandom_range(0, 2));
            md = int'($urandom_range(0, 3));
            r  = int'($urandom_range(1, 6));
            ctrl = 32'((((md << 1) | 1)) << (4 * ch));
            do_reset;
            wr(2'(ch), 32'(r));
            wr(2'd3, ctrl);
            n = 2 * (r + 1) + 3;
            for (int k = 0; k < n; k++) begin
                rd(2'(ch), v);
                exp_v = m_count(md, r, k);
                exp_outs = m_out(md, r, k) ? 3'(3'b001 << ch) : 3'b000;
                total++; if (v !== exp_v) $display("FAIL rnd_count ch=%0d md=%0d r=%0d k=%0d: got %0h want %0h", ch, md, r, k, v, exp_v); else passed++;
                total++; if (outs !== exp_outs) $display("FAIL rnd_out ch=%0d md=%0d r=%0d k=%0d: got %b want %b", ch, md, r, k, outs, exp_outs); else passed++;
                total++; if (irq !== (k >= r + 1)) $display("FAIL rnd_irq ch=%0d md=%0d r=%0d k=%0d: got %b want %b", ch, md, r, k, irq, (k >= r + 1)); else passed++;
                @(negedge clk);
            end
            rd(2'd3, v);
            exp_v = (32'h2000_0000 << ch) | ctrl;
            total++; if (v !== exp_v) $display("FAIL rnd_ctrl_read ch=%0d md=%0d: got %0h want %0h", ch, md, v, exp_v); else passed++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running want done");
        $fatal(1, "timeout");
    end

    initial begin
        bus.counter_we    = 1'b0;
        bus.counter_set   = 2'd0;
        bus.Peripheral_in = 32'd0;
        @(negedge clk);
        test_reset;
        test_oneshot;
        test_autoreload;
        test_square;
        test_collision;
        test_idle;
        test_random;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
